tablo_serilestirici: RTL and testbench

TABLO_SERILESTIRICI -- requirements
Module: tablo_serilestirici

---
 rtl/seri_paket.sv | 18 +
 rtl/bit_suresi_sayaci.sv | 28 ++
 rtl/tablo_serilestirici.sv | 78 +++++++
 tb/tb_tablo_serilestirici.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seri_paket.sv
// Shared definitions for the frame serializer: FSM encoding and default sizing.
package seri_paket;

   localparam int VARSAYILAN_GENISLIK   = 10;
   localparam int VARSAYILAN_BIT_SURESI = 1;

   typedef enum logic [1:0] {
      BOS    = 2'd0,
      GONDER = 2'd1,
      BITTI  = 2'd2
   } durum_t;

   // Index width that stays at least one bit wide for single-bit frames.
   function automatic int isaretci_genislik(input int g);
      return (g > 1) ? $clog2(g) : 1;
   endfunction

endpackage

// File: rtl/bit_suresi_sayaci.sv
// Bit-period counter: emits a one-cycle tick every BIT_SURESI enabled cycles.
module bit_suresi_sayaci #(
   parameter int BIT_SURESI = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic etkin,
   output logic tik
);

   localparam int SW = (BIT_SURESI > 1) ? $clog2(BIT_SURESI) : 1;

   logic [SW-1:0] sayac_q, sayac_d;

   assign tik = etkin && (sayac_q == SW'(BIT_SURESI - 1));

   // Counter restarts whenever disabled so every frame begins with a full period.
   always_comb begin
      sayac_d = sayac_q + SW'(1);
      if (!etkin || tik) sayac_d = '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sayac_q <= '0;
      else        sayac_q <= sayac_d;
   end

endmodule

// File: rtl/tablo_serilestirici.sv
// LSB-first frame serializer: captures a parallel frame on start and shifts it out.
module tablo_serilestirici
   import seri_paket::*;
#(
   parameter int GENISLIK   = VARSAYILAN_GENISLIK,
   parameter int BIT_SURESI = VARSAYILAN_BIT_SURESI
) (
   input  logic                                   clk,
   input  logic                                   rst_n,
   input  logic                                   baslat,
   input  logic [GENISLIK-1:0]                    tablo,
   output logic                                   bit_cikis,
   output logic                                   gecerli,
   output logic [isaretci_genislik(GENISLIK)-1:0] isaretci,
   output logic                                   mesgul,
   output logic                                   bitti_mi
);

   localparam int IW = isaretci_genislik(GENISLIK);

   durum_t              durum_q;
   logic [GENISLIK-1:0] cerceve_q;
   logic [IW-1:0]       isaretci_q, isaretci_d;
   logic                bit_q, gecerli_q, bitti_q;
   logic                tik;

   bit_suresi_sayaci #(.BIT_SURESI(BIT_SURESI)) u_sayac (
      .clk   (clk),
      .rst_n (rst_n),
      .etkin (durum_q == GONDER),
      .tik   (tik)
   );

   assign isaretci_d = isaretci_q + IW'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         durum_q    <= BOS;
         cerceve_q  <= '0;
         isaretci_q <= '0;
         bit_q      <= 1'b0;
         gecerli_q  <= 1'b0;
         bitti_q    <= 1'b0;
      end else begin
         bitti_q <= 1'b0;
         case (durum_q)
            BOS: if (baslat) begin
               cerceve_q  <= tablo;
               isaretci_q <= '0;
               bit_q      <= tablo[0];
               gecerli_q  <= 1'b1;
               durum_q    <= GONDER;
            end
            GONDER: if (tik) begin
               // Last bit held its full period: stop without wrapping the index.
               if (isaretci_q == IW'(GENISLIK - 1)) begin
                  bit_q     <= 1'b0;
                  gecerli_q <= 1'b0;
                  bitti_q   <= 1'b1;
                  durum_q   <= BITTI;
               end else begin
                  isaretci_q <= isaretci_d;
                  bit_q      <= cerceve_q[isaretci_d];
               end
            end
            BITTI:   durum_q <= BOS;
            default: durum_q <= BOS;
         endcase
      end
   end

   assign bit_cikis = bit_q;
   assign gecerli   = gecerli_q;
   assign isaretci  = isaretci_q;
   assign bitti_mi  = bitti_q;
   assign mesgul    = (durum_q != BOS);

endmodule

// File: tb/tb_tablo_serilestirici.sv
// Scenario bench for the frame serializer at BIT_SURESI=1 and BIT_SURESI=3.
module tb_tablo_serilestirici;

   localparam int G = 10;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst_n, baslat, baslat3;
   logic [G-1:0] tablo, tablo3;
   logic         bit_cikis, gecerli, mesgul, bitti_mi;
   logic         bit_cikis3, gecerli3, mesgul3, bitti_mi3;
   logic [3:0]   isaretci, isaretci3;

   tablo_serilestirici #(.GENISLIK(G), .BIT_SURESI(1)) u_dut (
      .clk(clk), .rst_n(rst_n), .baslat(baslat), .tablo(tablo),
      .bit_cikis(bit_cikis), .gecerli(gecerli), .isaretci(isaretci),
      .mesgul(mesgul), .bitti_mi(bitti_mi)
   );

   tablo_serilestirici #(.GENISLIK(G), .BIT_SURESI(3)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .baslat(baslat3), .tablo(tablo3),
      .bit_cikis(bit_cikis3), .gecerli(gecerli3), .isaretci(isaretci3),
      .mesgul(mesgul3), .bitti_mi(bitti_mi3)
   );

   // {mesgul, gecerli, bitti_mi, bit_cikis, isaretci}
   wire [7:0] gozlem  = {mesgul, gecerli, bitti_mi, bit_cikis, isaretci};
   wire [7:0] gozlem3 = {mesgul3, gecerli3, bitti_mi3, bit_cikis3, isaretci3};

   typedef struct packed {
      logic       b;
      logic [3:0] i;
   } bek_t;

   bek_t kuyruk[$];
   int   checks   = 0;
   int   failures = 0;

   task automatic push_frame(input logic [G-1:0] t, input int bs);
      for (int i = 0; i < G; i++)
         for (int k = 0; k < bs; k++) kuyruk.push_back('{b: t[i], i: 4'(i)});
   endtask

   task automatic test_reset();
      bek_t e;
      rst_n = 1'b0; baslat = 1'b0; baslat3 = 1'b0; tablo = '0; tablo3 = '0;
      #3;
      checks++;
      if (gozlem !== 8'h00) begin
         failures++; $display("FAIL reset_state got=%b exp=%b", gozlem, 8'h00);
      end
      checks++;
      if (gozlem3 !== 8'h00) begin
         failures++; $display("FAIL reset_state3 got=%b exp=%b", gozlem3, 8'h00);
      end
      repeat (3) @(negedge clk);
      rst_n = 1'b1; baslat = 1'b1; tablo = 10'h001;
      push_frame(tablo, 1);
      @(negedge clk);
      baslat = 1'b0;
      e = kuyruk.pop_front();
      checks++;
      if (gozlem !== {3'b110, e.b, e.i}) begin
         failures++; $display("FAIL reset_first_start got=%b exp=%b", gozlem, {3'b110, e.b, e.i});
      end
      kuyruk.delete();
      repeat (12) @(negedge clk);
   endtask

   task automatic test_basic();
      bek_t e;
      @(negedge clk);
      tablo = 10'b1011001101; baslat = 1'b1;
      push_frame(tablo, 1);
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         if (c == 1) baslat = 1'b0;
         if (c <= 10) begin
            e = kuyruk.pop_front();
            checks++;
            if (gozlem !== {3'b110, e.b, e.i}) begin
               failures++; $display("FAIL basic_bit c=%0d got=%b exp=%b", c, gozlem, {3'b110, e.b, e.i});
            end
         end else if (c == 11) begin
            checks++;
            if (gozlem[7:4] !== 4'b1010) begin
               failures++; $display("FAIL basic_bitti got=%b exp=1010", gozlem[7:4]);
            end
         end else begin
            checks++;
            if (gozlem[7:4] !== 4'b0000) begin
               failures++; $display("FAIL basic_idle got=%b exp=0000", gozlem[7:4]);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      bek_t e;
      @(negedge clk);
      tablo = 10'h2A5; baslat = 1'b1;
      push_frame(tablo, 1);
      for (int c = 1; c <= 25; c++) begin
         @(negedge clk);
         if (c == 1) begin
            tablo = 10'h1C3;
            push_frame(tablo, 1);
         end
         if ((c >= 1 && c <= 10) || (c >= 13 && c <= 22)) begin
            e = kuyruk.pop_front();
            checks++;
            if (gozlem !== {3'b110, e.b, e.i}) begin
               failures++; $display("FAIL b2b_bit c=%0d got=%b exp=%b", c, gozlem, {3'b110, e.b, e.i});
            end
         end else if (c == 11 || c == 23) begin
            checks++;
            if (gozlem[7:4] !== 4'b1010) begin
               failures++; $display("FAIL b2b_bitti c=%0d got=%b exp=1010", c, gozlem[7:4]);
            end
         end else begin
            checks++;
            if (gozlem[7:4] !== 4'b0000) begin
               failures++; $display("FAIL b2b_idle c=%0d got=%b exp=0000", c, gozlem[7:4]);
            end
         end
         if (c == 23) baslat = 1'b0;
      end
   endtask

   task automatic test_tablo_degisim();
      bek_t e;
      @(negedge clk);
      tablo = 10'b0110010110; baslat = 1'b1;
      push_frame(tablo, 1);
      for (int c = 1; c <= 11; c++) begin
         @(negedge clk);
         if (c == 1) baslat = 1'b0;
         if (c <= 10) begin
            e = kuyruk.pop_front();
            checks++;
            if (gozlem !== {3'b110, e.b, e.i}) begin
               failures++; $display("FAIL capture_bit c=%0d got=%b exp=%b", c, gozlem, {3'b110, e.b, e.i});
            end
            if (e.i == 4'd3) tablo = 10'h3FF;
         end else begin
            checks++;
            if (gozlem[7:4] !== 4'b1010) begin
               failures++; $display("FAIL capture_bitti got=%b exp=1010", gozlem[7:4]);
            end
         end
      end
      tablo = '0;
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      bek_t e;
      bit   gordu;
      @(negedge clk);
      tablo = 10'h3F0; baslat = 1'b1;
      push_frame(tablo, 1);
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         if (c == 1) baslat = 1'b0;
         e = kuyruk.pop_front();
         checks++;
         if (gozlem !== {3'b110, e.b, e.i}) begin
            failures++; $display("FAIL midrst_bit c=%0d got=%b exp=%b", c, gozlem, {3'b110, e.b, e.i});
         end
      end
      kuyruk.delete();
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if (gozlem !== 8'h00) begin
         failures++; $display("FAIL midrst_async got=%b exp=%b", gozlem, 8'h00);
      end
      rst_n = 1'b1;
      gordu = 1'b0;
      for (int c = 0; c < 15; c++) begin
         @(negedge clk);
         if (bitti_mi || gecerli || mesgul) gordu = 1'b1;
      end
      checks++;
      if (gordu !== 1'b0) begin
         failures++; $display("FAIL midrst_no_bitti got=%b exp=0", gordu);
      end
   endtask

   task automatic test_bitti_baslat();
      bek_t e;
      @(negedge clk);
      tablo = 10'h155; baslat = 1'b1;
      push_frame(tablo, 1);
      for (int c = 1; c <= 26; c++) begin
         @(negedge clk);
         if (c == 1 || c == 13 || c == 24) baslat = 1'b0;
         if ((c >= 1 && c <= 10) || (c >= 13 && c <= 22)) begin
            e = kuyruk.pop_front();
            checks++;
            if (gozlem !== {3'b110, e.b, e.i}) begin
               failures++; $display("FAIL bittistart_bit c=%0d got=%b exp=%b", c, gozlem, {3'b110, e.b, e.i});
            end
         end else if (c == 11 || c == 23) begin
            checks++;
            if (gozlem[7:4] !== 4'b1010) begin
               failures++; $display("FAIL bittistart_bitti c=%0d got=%b exp=1010", c, gozlem[7:4]);
            end
            baslat = 1'b1;
         end else begin
            checks++;
            if (gozlem[7:4] !== 4'b0000) begin
               failures++; $display("FAIL bittistart_idle c=%0d got=%b exp=0000", c, gozlem[7:4]);
            end
         end
         if (c == 12) push_frame(tablo, 1);
      end
   endtask

   task automatic test_bit_suresi3();
      bek_t e;
      @(negedge clk);
      tablo3 = 10'b0000000001; baslat3 = 1'b1;
      push_frame(tablo3, 3);
      for (int c = 1; c <= 32; c++) begin
         @(negedge clk);
         if (c == 1) baslat3 = 1'b0;
         if (c <= 30) begin
            e = kuyruk.pop_front();
            checks++;
            if (gozlem3 !== {3'b110, e.b, e.i}) begin
               failures++; $display("FAIL bs3_bit c=%0d got=%b exp=%b", c, gozlem3, {3'b110, e.b, e.i});
            end
         end else if (c == 31) begin
            checks++;
            if (gozlem3[7:4] !== 4'b1010) begin
               failures++; $display("FAIL bs3_bitti got=%b exp=1010", gozlem3[7:4]);
            end
         end else begin
            checks++;
            if (gozlem3[7:4] !== 4'b0000) begin
               failures++; $display("FAIL bs3_idle got=%b exp=0000", gozlem3[7:4]);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_tablo_degisim();
      test_reset_mid();
      test_bitti_baslat();
      test_bit_suresi3();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
